empaque_calcetines: RTL and testbench
=====================================

# empaque_calcetines

Packing stage directly downstream of the sock-factory FSM. Counts finished-sock pulses for each of the five sock kinds, groups them into packs of `PAIRS_PER_PACK` pairs, and arbitrates round-robin for one shared sealing machine. Keeps a saturating per-kind pack count for the front-panel display.

## Interface

**Parameters**
- `PAIRS_PER_PACK`, default 6: pairs per pack; legal range 1..7.
- `NKIND`, default 5: number of sock kinds, in order albajo, polbajo, acbajo, alalto, acalto.

**Ports**
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `sock_done`  in  NKIND  1-cycle pulse per finished single sock, one bit per kind. Several bits may be high in the same cycle.
- `seal_ack`  in  1  1-cycle pulse from the sealer: the current pack is sealed.
- `clr_cnt`  in  1  synchronous clear of all pack counts and overflow flags.
- `seal_req`  out  1  request to the sealer; held until `seal_ack`.
- `seal_kind`  out  3  index of the kind being sealed; stable while `seal_req` is high.
- `pack_cnt`  out  3×NKIND  sealed packs per kind (packed vector, kind 0 in LSBs); saturates at 7.
- `pack_full`  out  NKIND  `pack_cnt[k]==7`.
- `overflow`  out  NKIND  sticky: a pack completed while the previous pack of that kind was still unsealed.

## Operation

**Per-kind sock counter**
- `sock_cnt[k]` runs 0..2·PAIRS_PER_PACK−1 and increments on `sock_done[k]`.
- On the pulse that would reach 2·PAIRS_PER_PACK:
  - If `pending[k]==0`: `sock_cnt[k]` returns to 0 and `pending[k]` is set.
  - If `pending[k]==1`: `sock_cnt[k]` holds at 2·PAIRS_PER_PACK−1, the sock is dropped, and `overflow[k]` is set.

**Sealer FSM** (states IDLE, REQ)
- **IDLE**
  - If any `pending` bit is set, grant round-robin, starting at `last+1` mod NKIND.
  - Load `seal_kind` with the grant and go to REQ.
  - `last` resets to NKIND−1, so the first grant search starts at kind 0.
- **REQ**
  - `seal_req`=1.
  - On `seal_ack`: clear `pending[seal_kind]`, increment `pack_cnt[seal_kind]` (saturating at 7), set `last=seal_kind`, go to IDLE.
- `seal_ack` seen in IDLE is ignored.

**Boundary cases**
- If, in the same cycle as `seal_ack`, the same kind's counter completes a pack, the result is: `pending` stays 1, `sock_cnt` goes to 0, `pack_cnt` increments, and `overflow` is not set.
- `clr_cnt` clears `pack_cnt` and `overflow` only. Counters, `pending`, and the FSM are unaffected.
- If `clr_cnt` and `seal_ack` occur in the same cycle, `clr_cnt` wins (`pack_cnt` becomes 0), and `pending` is still cleared.

**Reset values**
- All counters, `pending`, `pack_cnt`, `overflow`, `seal_req`, and `seal_kind` are 0, and the FSM is in IDLE.
- Reset asserted mid-request drops `seal_req` the next edge. The in-flight pack is lost and is not counted.

## Timing

- `sock_done` at edge n → `sock_cnt` and `pending` updated at edge n+1.
- `pending` set at n+1 with the FSM in IDLE → `seal_req`=1 after edge n+2.
- `seal_ack` at edge m → `seal_req`=0, `pack_cnt` updated, `pending` cleared after m+1.
- The next grant can assert `seal_req` after m+2, giving one mandatory IDLE cycle between requests.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure

**Shared package** `calcetines_pkg` holds:
- The kind indices, named after the five kinds (albajo=0, polbajo=1, acbajo=2, alalto=3, acalto=4), and `NKIND`.
- The sealer state encoding.
- `PACK_MAX`=7.

**Sub-module** `contador_pares`: one sock counter with `pending`/`overflow` logic, instantiated NKIND times. The top level holds the arbiter, the FSM, and the pack counters.

## Test plan

Use PAIRS_PER_PACK=2 throughout.

- Four `sock_done[0]` pulses, `seal_ack` returned 3 cycles after `seal_req` rises → `seal_req` rises 2 cycles after the 4th pulse with `seal_kind`=0; `pack_cnt[0]`=1 and `seal_req`=0 one cycle after the ack.
- Kinds 1 and 3 complete packs in the same cycle → grants go 1 then 3, with one IDLE cycle between; both counts end at 1.
- Eight pulses to kind 2 with `seal_ack` held off → `overflow[2]`=1 and `sock_cnt[2]`=3. After the ack, `pack_cnt[2]`=1 and no second request is made.
- Eight packs sealed for kind 4 → `pack_cnt[4]` saturates at 7 and `pack_full[4]`=1. Then `clr_cnt` → count 0, flag 0.
- `reset` while `seal_req`=1 → all outputs 0 the next cycle; a later `seal_ack` has no effect.
- Pack completion for kind 0 in the same cycle as `seal_ack` for kind 0 → `pack_cnt[0]` increments, `pending[0]` stays set, a new request follows, and `overflow[0]`=0.

Source files
------------

// File: rtl/calcetines_pkg.sv
// calcetines_pkg: sock kind indices, sealer state encoding and pack limits shared by the packing stage
package calcetines_pkg;
  typedef enum logic [2:0] {ALBAJO, POLBAJO, ACBAJO, ALALTO, ACALTO} kind_e;
  localparam int NKIND = 5;
  typedef enum logic {S_IDLE, S_REQ} sealer_e;
  localparam logic [2:0] PACK_MAX = 3'd7;
endpackage

// File: rtl/contador_pares.sv
// contador_pares: per-kind sock counter that raises pending on a full pack and flags overflow
module contador_pares #(
  parameter int PAIRS_PER_PACK = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic sock_done_i,
  input  logic ack_i,
  input  logic clr_i,
  output logic pending_o,
  output logic overflow_o
);
  localparam logic [3:0] TOP = 4'(2 * PAIRS_PER_PACK - 1);
  logic [3:0] cnt_q, cnt_d;
  logic       pend_q, pend_d, ovf_q, ovf_d, wrap, busy;
  always_comb begin
    wrap   = sock_done_i && cnt_q == TOP;
    // an ack in the same cycle frees the slot, so the completing pack is accepted
    busy   = pend_q && !ack_i;
    cnt_d  = !sock_done_i ? cnt_q : !wrap ? cnt_q + 4'd1 : busy ? cnt_q : 4'd0;
    pend_d = wrap || busy;
    ovf_d  = !clr_i && (ovf_q || (wrap && busy));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;
endmodule

// File: rtl/empaque_calcetines.sv
// empaque_calcetines: groups finished socks into packs and arbitrates round-robin for the shared sealer
module empaque_calcetines #(
  parameter int PAIRS_PER_PACK = 6,
  parameter int NKIND          = calcetines_pkg::NKIND
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NKIND-1:0]     sock_done,
  input  logic                 seal_ack,
  input  logic                 clr_cnt,
  output logic                 seal_req,
  output logic [2:0]           seal_kind,
  output logic [3*NKIND-1:0]   pack_cnt,
  output logic [NKIND-1:0]     pack_full,
  output logic [NKIND-1:0]     overflow
);
  import calcetines_pkg::*;
  sealer_e                  state_q;
  logic                     seal_req_q;
  logic [2:0]               kind_q, last_q, grant;
  logic [3:0]               s;
  logic [NKIND-1:0]         pending, ack;
  logic [NKIND-1:0][2:0]    pack_q;
  // walk downward so the kind closest after last_q is the one that sticks
  always_comb begin
    grant = last_q;
    s     = '0;
    for (int i = NKIND; i >= 1; i--) begin
      s = {1'b0, last_q} + 4'(i);
      s = s >= 4'(NKIND) ? s - 4'(NKIND) : s;
      if (pending[s[2:0]]) grant = s[2:0];
    end
  end
  for (genvar g = 0; g < NKIND; g++) begin : g_kind
    assign ack[g]       = state_q == S_REQ && seal_ack && kind_q == 3'(g);
    assign pack_full[g] = pack_q[g] == PACK_MAX;
    contador_pares #(.PAIRS_PER_PACK(PAIRS_PER_PACK)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .sock_done_i(sock_done[g]),
      .ack_i      (ack[g]),
      .clr_i      (clr_cnt),
      .pending_o  (pending[g]),
      .overflow_o (overflow[g])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      seal_req_q <= 1'b0;
      kind_q     <= '0;
      last_q     <= 3'(NKIND - 1);
      pack_q     <= '0;
    end else begin
      if (clr_cnt) pack_q <= '0;
      else if (state_q == S_REQ && seal_ack && pack_q[kind_q] != PACK_MAX)
        pack_q[kind_q] <= pack_q[kind_q] + 3'd1;
      if (state_q == S_IDLE && |pending) begin
        state_q    <= S_REQ;
        seal_req_q <= 1'b1;
        kind_q     <= grant;
      end else if (state_q == S_REQ && seal_ack) begin
        state_q    <= S_IDLE;
        seal_req_q <= 1'b0;
        last_q     <= kind_q;
      end
    end
  end
  assign seal_req  = seal_req_q;
  assign seal_kind = kind_q;
  assign pack_cnt  = pack_q;
endmodule

// File: tb/tb_empaque_calcetines.sv
// tb_empaque_calcetines: directed and random stimulus checked against a sock/pack reference model
module tb_empaque_calcetines;
  localparam int NK = 5;
  localparam int PP = 2;
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NK-1:0]   sock_done = '0;
  logic            seal_ack = 1'b0;
  logic            clr_cnt = 1'b0;
  logic            seal_req;
  logic [2:0]      seal_kind;
  logic [3*NK-1:0] pack_cnt;
  logic [NK-1:0]   pack_full;
  logic [NK-1:0]   overflow;
  int total = 0;
  int bad = 0;
  int  m_socks[NK];
  bit  m_pend[NK];
  int  m_packs[NK];
  bit  m_ovf[NK];
  bit  m_req;
  int  m_kind, m_last;
  empaque_calcetines #(.PAIRS_PER_PACK(PP), .NKIND(NK)) dut (
    .clk      (clk),
    .reset    (reset),
    .sock_done(sock_done),
    .seal_ack (seal_ack),
    .clr_cnt  (clr_cnt),
    .seal_req (seal_req),
    .seal_kind(seal_kind),
    .pack_cnt (pack_cnt),
    .pack_full(pack_full),
    .overflow (overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_outputs();
    chk("req", seal_req, m_req);
    chk("kind", seal_kind, m_kind);
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("cnt%0d", k), pack_cnt[3*k +: 3], m_packs[k]);
      chk($sformatf("full%0d", k), pack_full[k], m_packs[k] == 7);
      chk($sformatf("ovf%0d", k), overflow[k], m_ovf[k]);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_socks[k] = 0; m_pend[k] = 0; m_packs[k] = 0; m_ovf[k] = 0;
    end
    m_req = 0; m_kind = 0; m_last = NK - 1;
  endtask
  task automatic do_reset();
    reset = 1'b1; sock_done = '0; seal_ack = 1'b0; clr_cnt = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_outputs();
  endtask
  task automatic step(input logic [NK-1:0] sd, input bit ak, input bit cl);
    bit any, acked, ak_k, done;
    int g;
    sock_done = sd; seal_ack = ak; clr_cnt = cl;
    @(posedge clk); #1;
    sock_done = '0; seal_ack = 1'b0; clr_cnt = 1'b0;
    acked = m_req && ak;
    any = 0; g = 0;
    for (int i = 1; i <= NK; i++)
      if (!any && m_pend[(m_last + i) % NK]) begin any = 1; g = (m_last + i) % NK; end
    for (int k = 0; k < NK; k++) begin
      ak_k = acked && m_kind == k;
      done = sd[k] && m_socks[k] + 1 == 2 * PP;
      if (done && m_pend[k] && !ak_k) m_ovf[k] = 1;
      else if (done) begin m_socks[k] = 0; m_pend[k] = 1; end
      else begin
        if (sd[k]) m_socks[k]++;
        if (ak_k) m_pend[k] = 0;
      end
      if (ak_k) m_packs[k] = m_packs[k] == 7 ? 7 : m_packs[k] + 1;
      if (cl) begin m_packs[k] = 0; m_ovf[k] = 0; end
    end
    if (m_req) begin
      if (ak) begin m_req = 0; m_last = m_kind; end
    end else if (any) begin
      m_req = 1; m_kind = g;
    end
    check_outputs();
  endtask
  task automatic wait_req(input int n);
    for (int i = 0; i < n && seal_req !== 1'b1; i++) step('0, 0, 0);
    chk("wait_req", seal_req, 1);
  endtask
  initial begin
    do_reset();
    // single kind-0 pack, ack three cycles after the request
    repeat (4) step(5'b00001, 0, 0);
    step('0, 0, 0);
    chk("t1_req_rise", seal_req, 1);
    chk("t1_kind", seal_kind, 0);
    repeat (2) step('0, 0, 0);
    step('0, 1, 0);
    chk("t1_cnt", pack_cnt[2:0], 1);
    chk("t1_req_drop", seal_req, 0);
    // kinds 1 and 3 together
    repeat (4) step(5'b01010, 0, 0);
    wait_req(3);
    chk("t2_kind1", seal_kind, 1);
    step('0, 1, 0);
    chk("t2_gap", seal_req, 0);
    step('0, 0, 0);
    chk("t2_req2", seal_req, 1);
    chk("t2_kind3", seal_kind, 3);
    step('0, 1, 0);
    chk("t2_cnt1", pack_cnt[5:3], 1);
    chk("t2_cnt3", pack_cnt[11:9], 1);
    // kind 2 overflows while its pack waits
    repeat (8) step(5'b00100, 0, 0);
    chk("t3_ovf", overflow[2], 1);
    wait_req(3);
    chk("t3_kind", seal_kind, 2);
    step('0, 1, 0);
    chk("t3_cnt", pack_cnt[8:6], 1);
    repeat (4) step('0, 0, 0);
    chk("t3_no_req", seal_req, 0);
    step(5'b00100, 0, 0);
    step('0, 0, 0);
    chk("t3_held_cnt", seal_req, 1);
    step('0, 1, 0);
    // kind 4 saturation then clear
    repeat (8) begin
      repeat (4) step(5'b10000, 0, 0);
      wait_req(4);
      step('0, 1, 0);
    end
    chk("t4_sat", pack_cnt[14:12], 7);
    chk("t4_full", pack_full[4], 1);
    step('0, 0, 1);
    chk("t4_clr", pack_cnt[14:12], 0);
    chk("t4_full_clr", pack_full[4], 0);
    // reset mid-request
    repeat (4) step(5'b00001, 0, 0);
    wait_req(4);
    do_reset();
    chk("t5_req", seal_req, 0);
    chk("t5_cnt", pack_cnt, 0);
    step('0, 1, 0);
    chk("t5_late_ack", pack_cnt, 0);
    // completion coinciding with ack of the same kind
    repeat (4) step(5'b00001, 0, 0);
    wait_req(4);
    repeat (3) step(5'b00001, 0, 0);
    step(5'b00001, 1, 0);
    chk("t6_cnt", pack_cnt[2:0], 1);
    chk("t6_ovf", overflow[0], 0);
    step('0, 0, 0);
    chk("t6_rereq", seal_req, 1);
    chk("t6_kind", seal_kind, 0);
    step('0, 1, 0);
    // random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 200) == 0) do_reset();
      else step(NK'($urandom) & NK'($urandom), $urandom_range(0, 2) == 0,
                $urandom_range(0, 60) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
